sprint1_input_seq: RTL

- Control sequencer between the PS/2 keyboard joystick decoder and the Sprint 1 core's player-input pins.
- Turns held direction keys into a steering quadrature pair (SteerA/SteerB).
- Turns gear up/down key presses into the core's 4-position gear-shifter lines.
- Stretches coin key presses into fixed-width coin pulses.
- Runs in the 48 MHz system domain; all key inputs are asynchronous to it.

---
 rtl/sprint1_input_seq.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sprint1_input_seq.sv
// sprint1_input_seq: conditions PS/2 key levels into Sprint 1 player-input pins.
// Steering quadrature, 4-position gear shifter, stretched coin pulse, start.
// Ports: clk, reset (async, active-high); left/right/gear_up/gear_down/coin/start
//   key levels (active-high, async); steer_a/steer_b quadrature; gear1_n..gear3_n
//   shifter lines (active-low); coin_n, start_n (active-low); gear_state = gear-1.
// Option: define STEER_ACCEL_EN to halve the step interval after 8 steps.
module sprint1_input_seq #(
   parameter int DEBOUNCE   = 48384,
   parameter int STEP_DIV   = 48384,
   parameter int COIN_PULSE = 2419200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left,
   input  logic       right,
   input  logic       gear_up,
   input  logic       gear_down,
   input  logic       coin,
   input  logic       start,
   output logic       steer_a,
   output logic       steer_b,
   output logic       gear1_n,
   output logic       gear2_n,
   output logic       gear3_n,
   output logic       coin_n,
   output logic       start_n,
   output logic [1:0] gear_state
);

   localparam int DW = (DEBOUNCE   > 1) ? $clog2(DEBOUNCE)   : 1;
   localparam int SW = (STEP_DIV   > 1) ? $clog2(STEP_DIV)   : 1;
   localparam int CW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
   localparam logic [CW-1:0] COIN_LAST = CW'(COIN_PULSE - 1);

   typedef enum logic [1:0] {D_NONE, D_RIGHT, D_LEFT} dir_t;
   typedef enum logic [1:0] {G1, G2, G3, G4} gear_t;

   // bit order: 0 left, 1 right, 2 gear_up, 3 gear_down, 4 coin, 5 start
   logic [5:0]    w_raw;
   logic [5:0]    r_sync1;
   logic [5:0]    r_sync2;
   logic [5:0]    r_db;
   logic [DW-1:0] r_db_cnt [6];

   assign w_raw = {start, coin, gear_down, gear_up, right, left};

   // Debounced bit flips once the synchronized value has disagreed
   // with it for DEBOUNCE consecutive cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         for (int i = 0; i < 6; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 6; i++) begin
            if (r_sync2[i] == r_db[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db[i]     <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
            end
         end
      end
   end

   // ---------------- steering ----------------
   dir_t          w_dir;
   dir_t          r_dir;
   logic [SW-1:0] r_int;
   logic [SW-1:0] w_int_last;
   logic [1:0]    r_phase;
   logic [1:0]    w_phase_nxt;
   logic          w_step_new;
   logic          w_step_rep;
   logic          w_step;
   logic          r_steer_a;
   logic          r_steer_b;

   always_comb begin
      w_dir = D_NONE;
      if (r_db[1] && !r_db[0])      w_dir = D_RIGHT;
      else if (r_db[0] && !r_db[1]) w_dir = D_LEFT;
   end

   // Any change into a direction (incl. reversal) steps at once.
   assign w_step_new = (w_dir != D_NONE) && (w_dir != r_dir);
   assign w_step_rep = (w_dir != D_NONE) && (w_dir == r_dir) &&
                       (r_int == w_int_last);
   assign w_step     = w_step_new | w_step_rep;

   always_comb begin
      w_phase_nxt = r_phase;
      if (w_step) begin
         if (w_dir == D_RIGHT) w_phase_nxt = r_phase + 2'd1;
         else                  w_phase_nxt = r_phase - 2'd1;
      end
   end

`ifdef STEER_ACCEL_EN
   localparam int HALF = (STEP_DIV / 2 > 1) ? STEP_DIV / 2 : 1;
   localparam logic [SW-1:0] HALF_LAST = SW'(HALF - 1);
   logic [3:0] r_nstep;

   assign w_int_last = (r_nstep == 4'd8) ? HALF_LAST : STEP_LAST;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           r_nstep <= '0;
      else if (w_dir == D_NONE)            r_nstep <= '0;
      else if (w_step_new)                 r_nstep <= 4'd1;
      else if (w_step_rep && r_nstep != 8) r_nstep <= r_nstep + 4'd1;
   end
`else
   assign w_int_last = STEP_LAST;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dir     <= D_NONE;
         r_int     <= '0;
         r_phase   <= '0;
         r_steer_a <= 1'b0;
         r_steer_b <= 1'b0;
      end else begin
         r_dir   <= w_dir;
         r_phase <= w_phase_nxt;
         if (w_dir == D_NONE || w_step) r_int <= '0;
         else                           r_int <= r_int + SW'(1);
         // Gray map: 0=00 1=01 2=11 3=10 as {b,a}
         r_steer_a <= w_phase_nxt[1] ^ w_phase_nxt[0];
         r_steer_b <= w_phase_nxt[1];
      end
   end

   // ---------------- gear, coin, start ----------------
   logic          r_up_q;
   logic          r_dn_q;
   logic          r_coin_q;
   logic          w_up_rise;
   logic          w_dn_rise;
   logic          w_coin_rise;
   gear_t         r_gear;
   gear_t         w_gear_nxt;
   logic [2:0]    r_gear_n;
   logic          r_coin_n;
   logic [CW-1:0] r_coin_cnt;
   logic          r_start_n;

   assign w_up_rise   = r_db[2] & ~r_up_q;
   assign w_dn_rise   = r_db[3] & ~r_dn_q;
   assign w_coin_rise = r_db[4] & ~r_coin_q;

   always_comb begin
      w_gear_nxt = r_gear;
      if (w_up_rise && !w_dn_rise) begin
         case (r_gear)
            G1:      w_gear_nxt = G2;
            G2:      w_gear_nxt = G3;
            default: w_gear_nxt = G4;
         endcase
      end else if (w_dn_rise && !w_up_rise) begin
         case (r_gear)
            G4:      w_gear_nxt = G3;
            G3:      w_gear_nxt = G2;
            default: w_gear_nxt = G1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_up_q     <= 1'b0;
         r_dn_q     <= 1'b0;
         r_coin_q   <= 1'b0;
         r_gear     <= G1;
         r_gear_n   <= 3'b011;
         r_coin_n   <= 1'b1;
         r_coin_cnt <= '0;
         r_start_n  <= 1'b1;
      end else begin
         r_up_q    <= r_db[2];
         r_dn_q    <= r_db[3];
         r_coin_q  <= r_db[4];
         r_start_n <= ~r_db[5];
         r_gear    <= w_gear_nxt;
         // {gear1_n, gear2_n, gear3_n}; G4 leaves all lines open
         case (w_gear_nxt)
            G1:      r_gear_n <= 3'b011;
            G2:      r_gear_n <= 3'b101;
            G3:      r_gear_n <= 3'b110;
            default: r_gear_n <= 3'b111;
         endcase
         // Edges during an active pulse are dropped, not queued.
         if (!r_coin_n) begin
            if (r_coin_cnt == '0) r_coin_n   <= 1'b1;
            else                  r_coin_cnt <= r_coin_cnt - CW'(1);
         end else if (w_coin_rise) begin
            r_coin_n   <= 1'b0;
            r_coin_cnt <= COIN_LAST;
         end
      end
   end

   assign steer_a    = r_steer_a;
   assign steer_b    = r_steer_b;
   assign gear1_n    = r_gear_n[2];
   assign gear2_n    = r_gear_n[1];
   assign gear3_n    = r_gear_n[0];
   assign coin_n     = r_coin_n;
   assign start_n    = r_start_n;
   assign gear_state = r_gear;

endmodule
